// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: request bundle, FSM states and port identifiers.
package dmem_arb_pkg;

  // Requests carry a full-width address; the top level uses only its low ADDR_WIDTH_P bits.
  localparam int unsigned ReqAddrWidth = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } dmem_arb_state_e;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_NET  = 1'b1
  } dmem_port_e;

  typedef struct packed {
    logic [ReqAddrWidth-1:0] addr;
    logic [31:0]             wdata;
    logic                    is_store;
    logic                    is_byte;
  } dmem_req_s;

  function automatic logic is_misaligned(dmem_req_s req);
    return !req.is_byte && (req.addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Byte-lane formatting: store replication and mask generation, load byte extraction
// with zero-extension.
module dmem_byte_lane (
  input  logic        is_store_i,
  input  logic        is_byte_i,
  input  logic [1:0]  wr_off_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        rd_is_store_i,
  input  logic        rd_is_byte_i,
  input  logic [1:0]  rd_off_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] rdata_o
);

  logic [31:0] rd_shifted;

  always_comb begin
    mem_wdata_o = wdata_i;
    mem_wmask_o = 4'h0;
    if (is_store_i) begin
      if (is_byte_i) begin
        mem_wdata_o = {4{wdata_i[7:0]}};
        mem_wmask_o = 4'b0001 << wr_off_i;
      end else begin
        mem_wmask_o = 4'hF;
      end
    end
  end

  always_comb begin
    rd_shifted = mem_rdata_i >> {rd_off_i, 3'b000};
    rdata_o    = 32'h0;
    if (!rd_is_store_i) begin
      rdata_o = rd_is_byte_i ? {24'h0, rd_shifted[7:0]} : mem_rdata_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-ported data memory between the core and the
// network/debug port, one outstanding access at a time.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH_P = 12
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    core_v_i,
  input  logic [ADDR_WIDTH_P-1:0] core_addr_i,
  input  logic [31:0]             core_wdata_i,
  input  logic                    core_is_store_i,
  input  logic                    core_is_byte_i,
  output logic                    core_yumi_o,
  output logic                    core_resp_v_o,
  output logic                    core_resp_err_o,
  output logic [31:0]             core_rdata_o,

  input  logic                    net_v_i,
  input  logic [ADDR_WIDTH_P-1:0] net_addr_i,
  input  logic [31:0]             net_wdata_i,
  input  logic                    net_is_store_i,
  input  logic                    net_is_byte_i,
  output logic                    net_yumi_o,
  output logic                    net_resp_v_o,
  output logic                    net_resp_err_o,
  output logic [31:0]             net_rdata_o,

  output logic                    mem_v_o,
  output logic                    mem_w_o,
  output logic [ADDR_WIDTH_P-3:0] mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  output logic [3:0]              mem_wmask_o,
  input  logic                    mem_ready_i,
  input  logic                    mem_rvalid_i,
  input  logic [31:0]             mem_rdata_i
);

  dmem_arb_state_e state_q, state_d;
  dmem_port_e      last_grant_q, last_grant_d;
  dmem_port_e      owner_q, owner_d;
  logic [1:0]      off_q, off_d;
  logic            is_store_q, is_store_d;
  logic            is_byte_q, is_byte_d;

  dmem_req_s  core_req, net_req, sel_req;
  dmem_port_e sel;
  logic       yumi, mem_v, resp_v, resp_err;
  logic [31:0] lane_wdata, lane_rdata;
  logic [3:0]  lane_wmask;
  logic        unused_addr_hi;

  always_comb begin
    core_req = '{addr: ReqAddrWidth'(core_addr_i), wdata: core_wdata_i,
                 is_store: core_is_store_i, is_byte: core_is_byte_i};
    net_req  = '{addr: ReqAddrWidth'(net_addr_i), wdata: net_wdata_i,
                 is_store: net_is_store_i, is_byte: net_is_byte_i};
  end

  // On a tie the port that did not win last time goes first.
  always_comb begin
    sel = PORT_NET;
    if (core_v_i && net_v_i) begin
      sel = (last_grant_q == PORT_NET) ? PORT_CORE : PORT_NET;
    end else if (core_v_i) begin
      sel = PORT_CORE;
    end
    sel_req = (sel == PORT_CORE) ? core_req : net_req;
  end

  assign unused_addr_hi = ^sel_req.addr;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    off_d        = off_q;
    is_store_d   = is_store_q;
    is_byte_d    = is_byte_q;
    yumi         = 1'b0;
    mem_v        = 1'b0;
    resp_v       = 1'b0;
    resp_err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (core_v_i || net_v_i) begin
          if (is_misaligned(sel_req)) begin
            yumi         = 1'b1;
            owner_d      = sel;
            last_grant_d = sel;
            state_d      = ERR;
          end else begin
            mem_v = 1'b1;
            // Without ready the grant is not committed, so the pointer stays put.
            if (mem_ready_i) begin
              yumi         = 1'b1;
              owner_d      = sel;
              last_grant_d = sel;
              off_d        = sel_req.addr[1:0];
              is_store_d   = sel_req.is_store;
              is_byte_d    = sel_req.is_byte;
              state_d      = BUSY;
            end
          end
        end
      end
      BUSY: begin
        if (mem_rvalid_i) begin
          resp_v  = 1'b1;
          state_d = IDLE;
        end
      end
      ERR: begin
        resp_v   = 1'b1;
        resp_err = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_NET;
      owner_q      <= PORT_CORE;
      off_q        <= 2'b00;
      is_store_q   <= 1'b0;
      is_byte_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      off_q        <= off_d;
      is_store_q   <= is_store_d;
      is_byte_q    <= is_byte_d;
    end
  end

  dmem_byte_lane u_byte_lane (
    .is_store_i    (sel_req.is_store),
    .is_byte_i     (sel_req.is_byte),
    .wr_off_i      (sel_req.addr[1:0]),
    .wdata_i       (sel_req.wdata),
    .mem_wdata_o   (lane_wdata),
    .mem_wmask_o   (lane_wmask),
    .rd_is_store_i (is_store_q),
    .rd_is_byte_i  (is_byte_q),
    .rd_off_i      (off_q),
    .mem_rdata_i   (mem_rdata_i),
    .rdata_o       (lane_rdata)
  );

  assign core_yumi_o     = yumi && (sel == PORT_CORE);
  assign net_yumi_o      = yumi && (sel == PORT_NET);
  assign core_resp_v_o   = resp_v && (owner_q == PORT_CORE);
  assign net_resp_v_o    = resp_v && (owner_q == PORT_NET);
  assign core_resp_err_o = core_resp_v_o && resp_err;
  assign net_resp_err_o  = net_resp_v_o && resp_err;
  assign core_rdata_o    = (core_resp_v_o && !resp_err) ? lane_rdata : 32'h0;
  assign net_rdata_o     = (net_resp_v_o && !resp_err) ? lane_rdata : 32'h0;

  assign mem_v_o     = mem_v;
  assign mem_w_o     = mem_v && sel_req.is_store;
  assign mem_addr_o  = mem_v ? sel_req.addr[ADDR_WIDTH_P-1:2] : '0;
  assign mem_wdata_o = mem_v ? lane_wdata : 32'h0;
  assign mem_wmask_o = mem_v ? lane_wmask : 4'h0;

endmodule
